turn_sequencer: RTL

- Controller that sequences tic-tac-toe moves between two requesters: Player (human input path) and CPU (move generator).
- Validates each requested cell against the external 9-cell board store, then issues the board write.
- Samples the external line detector after each write and declares winner or draw.
- Sits between the requesters, the board register store and the win detector; owns turn order and move count.

---
 rtl/ttt_pkg.sv | 30 +++
 rtl/req_edge_det.sv | 34 +++
 rtl/turn_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// Shared codes and state encoding for the tic-tac-toe turn sequencer.
package ttt_pkg;

  localparam int NUM_CELLS = 9;

  localparam logic [3:0] LAST_CELL = 4'(NUM_CELLS - 1);
  localparam logic [3:0] MAX_MOVES = 4'(NUM_CELLS);

  localparam logic [1:0] MARK_PLAYER = 2'd0;
  localparam logic [1:0] MARK_CPU    = 2'd1;
  localparam logic [1:0] MARK_EMPTY  = 2'd2;

  localparam logic [2:0] WIN_NONE = 3'd2;
  localparam logic [2:0] WIN_DRAW = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    CHECK,
    WRITE,
    EVAL,
    OVER
  } state_t;

  // Board mark for a requester (0 = Player, 1 = CPU).
  function automatic logic [1:0] mark_of(input logic who);
    return who ? MARK_CPU : MARK_PLAYER;
  endfunction

endpackage

// File: rtl/req_edge_det.sv
// Rising-edge qualifier for one requester. A rising edge on i_req arms a
// pending flag that survives until the sequencer takes it (or a new game
// flushes it), so a request raised out of turn is served once the turn
// comes round, while a level held after ack/nack never re-arms.
module req_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic i_req,
  input  logic i_take,
  input  logic i_flush,
  output logic o_pend
);

  logic r_req_q;
  logic r_pend;

  // Delay the request level and arm/disarm the pending flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_req_q <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_req_q <= i_req;
      if (i_req && !r_req_q) begin
        r_pend <= 1'b1;
      end else if (i_take || i_flush) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign o_pend = r_pend;

endmodule

// File: rtl/turn_sequencer.sv
// Tic-tac-toe turn sequencer: arbitrates Player/CPU moves, validates them
// against the external board store, writes the mark and evaluates the
// external line detector. Optional per-turn forfeit timer is enabled by
// defining TURN_TIMEOUT_EN.
//
// state | meaning
// IDLE  | after reset, waiting for start
// TURN  | waiting for the current owner's request
// CHECK | board_rd_addr = latched pos, validate cell
// WRITE | board write strobe and owner ack
// EVAL  | sample mover's line flag, decide win/draw/next turn
// OVER  | game finished, outputs hold until start
module turn_sequencer
  import ttt_pkg::*;
#(
  parameter logic FIRST_PLAYER   = 1'b0,
  parameter int   TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       p_req,
  input  logic [3:0] p_pos,
  output logic       p_ack,
  output logic       p_nack,
  input  logic       c_req,
  input  logic [3:0] c_pos,
  output logic       c_ack,
  output logic       c_nack,
  output logic [3:0] board_rd_addr,
  input  logic [1:0] board_rd_data,
  output logic       board_we,
  output logic [3:0] board_addr,
  output logic [1:0] board_wdata,
  output logic       board_clr,
  input  logic       win_p,
  input  logic       win_c,
  output logic       turn,
  output logic [3:0] move_cnt,
  output logic [2:0] winner,
  output logic       game_over,
  output logic       timeout
);

  state_t     r_state, w_state_nxt;
  logic       r_turn, w_turn_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [2:0] r_winner, w_winner_nxt;
  logic       r_over, w_over_nxt;
  logic [3:0] r_pos, w_pos_nxt;
  logic       r_we, w_we_nxt;
  logic       r_clr, w_clr_nxt;
  logic       r_pack, w_pack_nxt;
  logic       r_pnack, w_pnack_nxt;
  logic       r_cack, w_cack_nxt;
  logic       r_cnack, w_cnack_nxt;
  logic       r_tmo, w_tmo_nxt;

  logic w_p_pend, w_c_pend;
  logic w_new_game, w_take, w_take_p, w_take_c;
  logic w_pos_bad, w_flag, w_tmr_hit;

  assign w_new_game = start && ((r_state == IDLE) || (r_state == OVER));
  assign w_take     = (r_state == TURN) && (r_turn ? w_c_pend : w_p_pend);
  assign w_take_p   = w_take && !r_turn;
  assign w_take_c   = w_take && r_turn;
  assign w_pos_bad  = (r_pos > LAST_CELL) || (board_rd_data != MARK_EMPTY);
  assign w_flag     = r_turn ? win_c : win_p;

  req_edge_det u_p_edge (
    .clock   (clock),
    .reset   (reset),
    .i_req   (p_req),
    .i_take  (w_take_p),
    .i_flush (w_new_game),
    .o_pend  (w_p_pend)
  );

  req_edge_det u_c_edge (
    .clock   (clock),
    .reset   (reset),
    .i_req   (c_req),
    .i_take  (w_take_c),
    .i_flush (w_new_game),
    .o_pend  (w_c_pend)
  );

`ifdef TURN_TIMEOUT_EN
  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_tmr, w_tmr_nxt;

  // A taken request in the terminal cycle beats the forfeit.
  assign w_tmr_hit = (r_state == TURN) && !w_take && (r_tmr == TMR_LAST);

  // Counter sits at zero outside TURN, so entering TURN always starts fresh.
  always_comb begin
    w_tmr_nxt = r_tmr + 16'd1;
    if ((r_state != TURN) || w_take || w_tmr_hit) begin
      w_tmr_nxt = '0;
    end
  end

  // Turn timer register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= w_tmr_nxt;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_tmr_hit    = 1'b0;
`endif

  // Next-state and next-output decode; pulses default low every cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_turn_nxt   = r_turn;
    w_cnt_nxt    = r_cnt;
    w_winner_nxt = r_winner;
    w_over_nxt   = r_over;
    w_pos_nxt    = r_pos;
    w_we_nxt     = 1'b0;
    w_clr_nxt    = 1'b0;
    w_pack_nxt   = 1'b0;
    w_pnack_nxt  = 1'b0;
    w_cack_nxt   = 1'b0;
    w_cnack_nxt  = 1'b0;
    w_tmo_nxt    = 1'b0;
    case (r_state)
      IDLE, OVER: begin
        if (start) begin
          w_clr_nxt    = 1'b1;
          w_cnt_nxt    = '0;
          w_winner_nxt = WIN_NONE;
          w_over_nxt   = 1'b0;
          w_turn_nxt   = FIRST_PLAYER;
          w_state_nxt  = TURN;
        end
      end
      TURN: begin
        if (w_take) begin
          w_pos_nxt   = r_turn ? c_pos : p_pos;
          w_state_nxt = CHECK;
        end else if (w_tmr_hit) begin
          w_tmo_nxt  = 1'b1;
          w_turn_nxt = !r_turn;
        end
      end
      CHECK: begin
        if (w_pos_bad) begin
          w_pnack_nxt = !r_turn;
          w_cnack_nxt = r_turn;
          w_state_nxt = TURN;
        end else begin
          w_we_nxt    = 1'b1;
          w_pack_nxt  = !r_turn;
          w_cack_nxt  = r_turn;
          if (r_cnt != MAX_MOVES) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        w_state_nxt = EVAL;
      end
      EVAL: begin
        if (w_flag) begin
          w_winner_nxt = {2'b00, r_turn};
          w_over_nxt   = 1'b1;
          w_state_nxt  = OVER;
        end else if (r_cnt == MAX_MOVES) begin
          w_winner_nxt = WIN_DRAW;
          w_over_nxt   = 1'b1;
          w_state_nxt  = OVER;
        end else begin
          w_turn_nxt  = !r_turn;
          w_state_nxt = TURN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and move bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_turn   <= FIRST_PLAYER;
      r_cnt    <= '0;
      r_winner <= WIN_NONE;
      r_over   <= 1'b0;
      r_pos    <= '0;
      r_we     <= 1'b0;
      r_clr    <= 1'b0;
      r_pack   <= 1'b0;
      r_pnack  <= 1'b0;
      r_cack   <= 1'b0;
      r_cnack  <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_turn   <= w_turn_nxt;
      r_cnt    <= w_cnt_nxt;
      r_winner <= w_winner_nxt;
      r_over   <= w_over_nxt;
      r_pos    <= w_pos_nxt;
      r_we     <= w_we_nxt;
      r_clr    <= w_clr_nxt;
      r_pack   <= w_pack_nxt;
      r_pnack  <= w_pnack_nxt;
      r_cack   <= w_cack_nxt;
      r_cnack  <= w_cnack_nxt;
      r_tmo    <= w_tmo_nxt;
    end
  end

  assign p_ack         = r_pack;
  assign p_nack        = r_pnack;
  assign c_ack         = r_cack;
  assign c_nack        = r_cnack;
  assign board_rd_addr = r_pos;
  assign board_we      = r_we;
  assign board_addr    = r_pos;
  assign board_wdata   = mark_of(r_turn);
  assign board_clr     = r_clr;
  assign turn          = r_turn;
  assign move_cnt      = r_cnt;
  assign winner        = r_winner;
  assign game_over     = r_over;
  assign timeout       = r_tmo;

endmodule
